encoder_n_to_logn_rr: RTL and testbench
=======================================

# encoder_N_to_logN_rr

Registered round-robin encoder: the reverse of the log2(N)-to-N address decoder. It collects up to N single-bit request strobes from the one-hot side, queues them as a pending bitmap, and emits one binary index per grant over a valid/ready handshake. It sits where one-hot event lines such as per-channel "data ready" flags feed a single address bus that selects the channel to service.

## Interface
Parameters:
- N, 8, number of request lines; N ≥ 1
- ADDR_WIDTH, (N > 1) ? $clog2(N) : 1, index width; localparam, derived and not overridable

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  N  request strobes; bit i high for any cycle raises request i
- enable  in  1  1 = grants may be issued; 0 = no new grant (pending still accumulates)
- addr_out  out  ADDR_WIDTH  index of granted request
- valid_out  out  1  addr_out holds a grant
- ready_in  in  1  consumer accepts addr_out when valid_out && ready_in at a rising edge
- pending  out  N  registered bitmap of requests not yet granted
- coalesced  out  1  one-cycle pulse: a req bit arrived while that bit was already pending (merged, not counted twice)

## Operation
- Reset (rst_n low, asynchronous): pending=0, addr_out=0, valid_out=0, coalesced=0, round-robin pointer ptr=0.
- pending update each edge: pending_next = (pending & ~grant_mask) | req. Set wins: if req[i] is high in the same cycle that bit i is granted, pending[i] stays 1.
- coalesced_next = |(req & pending & ~grant_mask).
- Two-state FSM on valid_out:
  - EMPTY (valid_out=0): if enable && |pending, grant and go to FULL.
  - FULL (valid_out=1): addr_out is held stable. If ready_in: if enable && |pending, grant again in the same edge and stay FULL; otherwise go to EMPTY.
  - In FULL with ready_in=0, nothing changes except pending accumulating new requests.
- Grant selection: the first set bit of pending searched from ptr upward, wrapping from N-1 to 0. On grant: addr_out <= idx, grant_mask = 1<<idx, ptr <= (idx == N-1) ? 0 : idx+1.
- enable going low never withdraws a grant that is already valid. That grant is held until it is accepted.
- Non-power-of-2 N: ptr and addr_out never take values ≥ N.
- N=1: addr_out is always 0.
- Grants reflect pending as registered; the current cycle's req is not bypassed into the selection.

## Timing
- Latency: req[i] high before edge E0 gives pending[i]=1 after E0. With the output free and enable=1, valid_out=1 and addr_out=i after E0+1, and pending[i] clears at E0+1.
- Throughput: one grant per cycle while ready_in=1 and pending is non-zero.
- Handshake: valid_out and addr_out never change while valid_out && !ready_in.
- coalesced is registered and asserts the edge after the duplicate req.
- Reset asserted mid-operation clears every register immediately. Any grant in flight is lost. After rst_n releases, the first grant happens no earlier than the second edge.

## Structure
- Shared package cdc_pkg: the function addr_width(n) that returns (n>1)?$clog2(n):1. It is shared with decoder_logN_to_N.
- One combinational sub-module, rr_first_set #(N): inputs vec[N-1:0] and ptr; outputs found and idx. It performs the rotate, find-first-set, and un-rotate.
- Top level: pending register, ptr register, output register, FSM.

## Test plan
- Single request with ready_in=1, N=8: req=8'b0000_0100 for 1 cycle → after 2 edges valid_out=1 and addr_out=2 for one cycle; pending returns to 0.
- Round-robin fairness: req=8'hFF held for 1 cycle, ready_in=1 → addr_out sequence 0,1,...,7 on consecutive cycles. Then re-issue req=8'h81 with ptr=0 → grants 0, then 7.
- Backpressure: ready_in=0 with 3 requests pending → addr_out is frozen at its first value. Assert ready_in → the remaining 2 grants issue on back-to-back cycles.
- Coalescing and set-wins: req[5] pulsed twice while pending[5]=1 → coalesced pulses once per duplicate and bit 5 is granted exactly once. Then pulse req[5] on the exact cycle of its grant → it is granted a second time.
- enable low: enable=0 with req=8'h0F → no valid_out and pending=8'h0F. Set enable=1 → grants 0, 1, 2, 3 follow.
- N=5 wrap and reset: grants reach index 4, then ptr wraps to 0 and addr_out is never ≥ 5. Pull rst_n low while valid_out=1 → all outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared helpers for the one-hot/binary address encoder and decoder blocks.
package cdc_pkg;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } rr_state_e;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_first_set.sv
// Round-robin find-first-set: first set bit of vec at or above ptr, wrapping from N-1 to 0.
module rr_first_set
    import cdc_pkg::*;
#(
    parameter  int N  = 8,
    localparam int AW = addr_width(N)
) (
    input  logic [N-1:0]  vec,
    input  logic [AW-1:0] ptr,
    output logic          found,
    output logic [AW-1:0] idx
);

    localparam logic [AW:0] NW = (AW+1)'(N);

    logic [N-1:0]  w_rot;
    logic [AW-1:0] w_pos;
    logic [AW:0]   w_sum;

    // Rotate so that position ptr lands at bit 0.
    always_comb begin
        w_rot = '0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = k + int'(ptr);
            if (j >= N) j = j - N;
            w_rot[k] = vec[j];
        end
    end

    always_comb begin
        found = 1'b0;
        w_pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                found = 1'b1;
                w_pos = AW'(k);
            end
        end
    end

    // Un-rotate; the extra sum bit keeps ptr+pos from overflowing before the wrap.
    assign w_sum = {1'b0, ptr} + {1'b0, w_pos};
    assign idx   = (w_sum >= NW) ? AW'(w_sum - NW) : w_sum[AW-1:0];

endmodule

// File: rtl/encoder_n_to_logn_rr.sv
// Registered round-robin encoder: queues one-hot request strobes and hands out one
// binary index per valid/ready transfer.
module encoder_n_to_logn_rr
    import cdc_pkg::*;
#(
    parameter  int N          = 8,
    localparam int ADDR_WIDTH = addr_width(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          req,
    input  logic                  enable,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [N-1:0]          pending,
    output logic                  coalesced
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N - 1);

    rr_state_e             r_state;
    rr_state_e             w_state_nxt;
    logic [N-1:0]          r_pending;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_coal;

    logic                  w_found;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_grant;
    logic [N-1:0]          w_gmask;
    logic [ADDR_WIDTH-1:0] w_ptr_nxt;

    rr_first_set #(.N(N)) u_rr_first_set (
        .vec   (r_pending),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    // A held grant is only released by ready_in; enable merely gates new grants.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (enable && w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (ready_in) begin
                    if (enable && w_found) begin
                        w_grant = 1'b1;
                    end else begin
                        w_state_nxt = S_EMPTY;
                    end
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        w_gmask = '0;
        if (w_grant) w_gmask[w_idx] = 1'b1;
    end

    assign w_ptr_nxt = (w_idx == LAST) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_EMPTY;
            r_pending <= '0;
            r_ptr     <= '0;
            r_addr    <= '0;
            r_coal    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            // OR-ing req last makes a same-cycle re-request survive its own grant.
            r_pending <= (r_pending & ~w_gmask) | req;
            r_coal    <= |(req & r_pending & ~w_gmask);
            if (w_grant) begin
                r_addr <= w_idx;
                r_ptr  <= w_ptr_nxt;
            end
        end
    end

    assign addr_out  = r_addr;
    assign valid_out = (r_state == S_FULL);
    assign pending   = r_pending;
    assign coalesced = r_coal;

endmodule

// File: tb/tb_encoder_n_to_logn_rr.sv
// Table-driven bench for the round-robin encoder (N=8) plus hand sequences for N=5 and async reset.
module tb_encoder_n_to_logn_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req8;
    logic       en8, rdy8;
    logic [2:0] addr8;
    logic       vld8;
    logic [7:0] pend8;
    logic       coal8;

    logic [4:0] req5;
    logic       en5, rdy5;
    logic [2:0] addr5;
    logic       vld5;
    logic [4:0] pend5;
    logic       coal5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    encoder_n_to_logn_rr #(.N(8)) u8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .enable(en8),
        .addr_out(addr8), .valid_out(vld8), .ready_in(rdy8),
        .pending(pend8), .coalesced(coal8)
    );

    encoder_n_to_logn_rr #(.N(5)) u5 (
        .clk(clk), .rst_n(rst_n), .req(req5), .enable(en5),
        .addr_out(addr5), .valid_out(vld5), .ready_in(rdy5),
        .pending(pend5), .coalesced(coal5)
    );

    typedef struct {
        bit         rst;
        logic [7:0] req;
        logic       en;
        logic       rdy;
        logic       ev;
        logic [2:0] ea;
        logic [7:0] ep;
        logic       ec;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, logic [7:0] rq, logic en, logic rdy,
                                logic ev, logic [2:0] ea, logic [7:0] ep, logic ec);
        vec_t v;
        v.rst = rst; v.req = rq; v.en = en; v.rdy = rdy;
        v.ev = ev; v.ea = ea; v.ep = ep; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req8 = '0; en8 = 1'b0; rdy8 = 1'b0;
        req5 = '0; en5 = 1'b0; rdy5 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // rst  req    en rdy  v  a  pend  c
        // single request, 2-edge latency
        vecs.push_back(mk(1, 8'h04, 1, 1, 0, 0, 8'h04, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1, 2, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 2, 8'h00, 0));
        // fairness sweep 0..7, then 0x81 -> 0, 7
        vecs.push_back(mk(1, 8'hFF, 1, 1, 0, 0, 8'hFF, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1, 0, 8'hFE, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1, 1, 8'hFC, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1, 2, 8'hF8, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1, 3, 8'hF0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1, 4, 8'hE0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1, 5, 8'hC0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1, 6, 8'h80, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1, 7, 8'h00, 0));
        vecs.push_back(mk(0, 8'h81, 1, 1, 0, 7, 8'h81, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1, 0, 8'h80, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1, 7, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 7, 8'h00, 0));
        // backpressure and enable-low while holding
        vecs.push_back(mk(1, 8'h16, 1, 0, 0, 0, 8'h16, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h14, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h14, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h14, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0, 1, 8'h14, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1, 2, 8'h10, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1, 4, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 4, 8'h00, 0));
        // coalescing, single grant, then set-wins re-grant
        vecs.push_back(mk(1, 8'h20, 0, 1, 0, 0, 8'h20, 0));
        vecs.push_back(mk(0, 8'h20, 0, 1, 0, 0, 8'h20, 1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h20, 0));
        vecs.push_back(mk(0, 8'h20, 0, 1, 0, 0, 8'h20, 1));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1, 5, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 5, 8'h00, 0));
        vecs.push_back(mk(0, 8'h20, 1, 1, 0, 5, 8'h20, 0));
        vecs.push_back(mk(0, 8'h20, 1, 1, 1, 5, 8'h20, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1, 5, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 5, 8'h00, 0));
        // enable low accumulates, then grants 0..3
        vecs.push_back(mk(1, 8'h0F, 0, 1, 0, 0, 8'h0F, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h0F, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h0F, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1, 0, 8'h0E, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1, 1, 8'h0C, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1, 2, 8'h08, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 1, 3, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 3, 8'h00, 0));

        rst_n = 1'b0;
        req8 = '0; en8 = 1'b0; rdy8 = 1'b0;
        req5 = '0; en5 = 1'b0; rdy5 = 1'b0;
        #12;
        chk("reset.valid", 32'(vld8), 32'd0);
        chk("reset.addr", 32'(addr8), 32'd0);
        chk("reset.pending", 32'(pend8), 32'd0);
        chk("reset.coalesced", 32'(coal8), 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            req8 = vecs[i].req; en8 = vecs[i].en; rdy8 = vecs[i].rdy;
            @(posedge clk); #1;
            chk($sformatf("row%0d.valid", i), 32'(vld8), 32'(vecs[i].ev));
            chk($sformatf("row%0d.addr", i), 32'(addr8), 32'(vecs[i].ea));
            chk($sformatf("row%0d.pending", i), 32'(pend8), 32'(vecs[i].ep));
            chk($sformatf("row%0d.coalesced", i), 32'(coal8), 32'(vecs[i].ec));
        end

        // N=5: sweep 0..4, pointer wraps, then 0x11 grants 0 before 4
        do_reset();
        en5 = 1'b1; rdy5 = 1'b1; req5 = 5'h1F;
        @(posedge clk); #1;
        chk("n5.load.pending", 32'(pend5), 32'h1F);
        chk("n5.load.valid", 32'(vld5), 32'd0);
        req5 = '0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("n5.sweep%0d.valid", k), 32'(vld5), 32'd1);
            chk($sformatf("n5.sweep%0d.addr", k), 32'(addr5), 32'(k));
        end
        req5 = 5'h11;
        @(posedge clk); #1;
        chk("n5.idle.valid", 32'(vld5), 32'd0);
        chk("n5.idle.pending", 32'(pend5), 32'h11);
        req5 = '0;
        @(posedge clk); #1;
        chk("n5.wrap0.addr", 32'(addr5), 32'd0);
        @(posedge clk); #1;
        chk("n5.wrap4.addr", 32'(addr5), 32'd4);
        chk("n5.wrap4.inrange", 32'(addr5 < 3'd5), 32'd1);
        rdy5 = 1'b0; req5 = 5'h06;
        @(posedge clk); #1;
        chk("n5.hold.valid", 32'(vld5), 32'd1);
        chk("n5.hold.addr", 32'(addr5), 32'd4);
        chk("n5.hold.pending", 32'(pend5), 32'h06);

        // Async reset between edges while a grant is held.
        req5 = '0;
        #3 rst_n = 1'b0;
        #1;
        chk("n5.areset.valid", 32'(vld5), 32'd0);
        chk("n5.areset.addr", 32'(addr5), 32'd0);
        chk("n5.areset.pending", 32'(pend5), 32'd0);
        chk("n5.areset.coalesced", 32'(coal5), 32'd0);
        #10 rst_n = 1'b1;
        #20;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
